alu_muldiv: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Companion to the combinational ALU in the EX stage; handles MULT, MULTU, DIV, DIVU, MTHI and MTLO; HI/LO are read by MFHI/MFLO.
- Radix-2 shift-add multiplier and restoring divider; start/busy/done handshake lets the pipeline stall on HI/LO hazards.

---
 rtl/alu_muldiv_if.sv | 37 +++
 rtl/alu_muldiv.sv | 212 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_if
//  Description : Request/result bundle between the EX stage and the
//                iterative multiply/divide unit (alu_muldiv).
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             abort;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    // Pipeline side: issues operations and reads HI/LO
    modport master (
        output start, op, A, B, abort, mthi, mtlo, wdata,
        input  hi, lo, busy, done, div0
    );

    // Unit side
    modport slave (
        input  start, op, A, B, abort, mthi, mtlo, wdata,
        output hi, lo, busy, done, div0
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Iterative multiply/divide unit with architectural HI/LO.
//                Radix-2 shift-add multiplier and restoring divider working
//                on operand magnitudes; signs are applied in the FIX state.
//                Optional macro ALU_MULDIV_EARLY_TERM_EN ends multiply
//                iterations once the remaining multiplier bits are zero.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    alu_muldiv_if.slave bus
);

    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [DW-1:0]    acc_q, acc_d;      // product, or {remainder, quotient}
    logic [DW-1:0]    mcand_q, mcand_d;  // shifted multiplicand, or divisor
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] araw_q, araw_d;    // raw dividend for the B==0 result
    logic             sa_q, sa_d;        // A negative and op is signed
    logic             sb_q, sb_d;        // B negative and op is signed
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    // Operand magnitudes at launch
    logic             in_signed;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One iteration of each datapath
    logic [DW-1:0]    mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [DW-1:0]    div_next;

    // Final sign correction
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign in_signed = ~bus.op[0];
    assign a_mag     = (in_signed && bus.A[WIDTH-1]) ? (WIDTH'(0) - bus.A) : bus.A;
    assign b_mag     = (in_signed && bus.B[WIDTH-1]) ? (WIDTH'(0) - bus.B) : bus.B;

    assign mul_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Restoring step: shift {rem,quo} left one bit, try subtracting divisor.
    assign rem_sh    = acc_q[DW-1:WIDTH-1];
    assign trial     = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
    assign div_next  = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix  = (sa_q ^ sb_q) ? (DW'(0) - acc_q) : acc_q;
    assign quo_fix   = (sa_q ^ sb_q) ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix   = sa_q ? (WIDTH'(0) - acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];

    // State, datapath and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            araw_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            araw_q   <= araw_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    // Next-state, iteration and result logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        araw_d   = araw_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = div0_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // abort in the same cycle suppresses the launch; the
                    // HI/LO moves are dropped whenever start is present
                    if (!bus.abort) begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(WIDTH);
                        op_d    = bus.op;
                        araw_d  = bus.A;
                        sa_d    = in_signed & bus.A[WIDTH-1];
                        sb_d    = in_signed & bus.B[WIDTH-1];
                        divz_d  = (bus.B == '0);
                        div0_d  = 1'b0;
                        if (bus.op[1]) begin
                            acc_d    = {{WIDTH{1'b0}}, a_mag};
                            mcand_d  = {{WIDTH{1'b0}}, b_mag};
                            mplier_d = '0;
                        end else begin
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a_mag};
                            mplier_d = b_mag;
                        end
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end

            S_CALC: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[1]) begin
                        acc_d = div_next;
                    end else begin
                        acc_d    = mul_sum;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
`ifdef ALU_MULDIV_EARLY_TERM_EN
                    // Nothing left to add once the multiplier is exhausted
                    if (!op_q[1] && ((mplier_q >> 1) == '0)) begin
                        state_d = S_FIX;
                    end
`endif
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.abort) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        if (divz_q) begin
                            hi_d   = araw_q;
                            lo_d   = '1;
                            div0_d = 1'b1;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end else begin
                        hi_d = prod_fix[DW-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done = done_q;
    assign bus.div0 = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Directed self-checking bench for alu_muldiv (WIDTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   busy_bad;
    int   lat;
    int   done_seen;

    alu_muldiv_if #(.WIDTH(32)) bif ();

    alu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected cycles from the start edge to done
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        int r;
        r = 33;
`ifdef ALU_MULDIV_EARLY_TERM_EN
        if (!o[1]) begin
            logic [31:0] m;
            int len;
            m   = (!o[0] && b[31]) ? (32'd0 - b) : b;
            len = 1;
            for (int i = 0; i < 32; i++) if (m[i]) len = i + 1;
            r = len + 1;
        end
`else
        if (o[1] && b[0]) r = 33;
`endif
        return r;
    endfunction

    // Launch at posedge+1, scramble operands after capture, wait for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int l);
        bif.start = 1'b1;
        bif.op    = o;
        bif.A     = a;
        bif.B     = b;
        @(posedge clk); #1;
        bif.start = 1'b0;
        bif.mthi  = 1'b0;
        bif.mtlo  = 1'b0;
        bif.A     = 32'hA5A5_A5A5;
        bif.B     = 32'h5A5A_5A5A;
        bif.op    = ~o;
        busy_bad  = (bif.busy === 1'b1) ? 0 : 1;
        l = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (bif.done === 1'b1) begin
                l = n;
                break;
            end
            if (bif.busy !== 1'b1) busy_bad++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bif.start   = 1'b0;
        bif.op      = 2'b00;
        bif.A       = '0;
        bif.B       = '0;
        bif.abort   = 1'b0;
        bif.mthi    = 1'b0;
        bif.mtlo    = 1'b0;
        bif.wdata   = '0;

        #23;
        check("reset_hilo", {bif.hi, bif.lo}, 64'd0);
        check("reset_flags", {61'd0, bif.busy, bif.done, bif.div0}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MULT -3 * 7
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat);
        check("mult_lat", 64'(lat), 64'(exp_lat(OP_MULT, 32'd7)));
        check("mult_busy_during", 64'(busy_bad), 64'd0);
        check("mult_busy_at_done", {63'd0, bif.busy}, 64'd0);
        check("mult_res", {bif.hi, bif.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge clk); #1;
        check("mult_done_pulse", {63'd0, bif.done}, 64'd0);

        // MULTU max * max
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_lat", 64'(lat), 64'(exp_lat(OP_MULTU, 32'hFFFF_FFFF)));
        check("multu_res", {bif.hi, bif.lo}, 64'hFFFF_FFFE_0000_0001);

        // MULT 5 * -4
        run_op(OP_MULT, 32'd5, 32'hFFFF_FFFC, lat);
        check("mult_negb_res", {bif.hi, bif.lo}, 64'hFFFF_FFFF_FFFF_FFEC);

        // DIV -7 / 2
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", 64'(lat), 64'd33);
        check("div_neg_res", {bif.hi, bif.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIVU 7 / 2
        run_op(OP_DIVU, 32'd7, 32'd2, lat);
        check("divu_res", {bif.hi, bif.lo}, 64'h0000_0001_0000_0003);

        // DIV 7 / -2
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat);
        check("div_negb_res", {bif.hi, bif.lo}, 64'h0000_0001_FFFF_FFFD);

        // DIV most-negative / -1
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_ovf_res", {bif.hi, bif.lo}, 64'h0000_0000_8000_0000);

        // DIVU 5 / 0
        run_op(OP_DIVU, 32'd5, 32'd0, lat);
        check("div0_lat", 64'(lat), 64'd33);
        check("div0_res", {bif.hi, bif.lo}, 64'h0000_0005_FFFF_FFFF);
        check("div0_flag", {63'd0, bif.div0}, 64'd1);

        // MULTU 2*3 clears div0 at its start
        bif.start = 1'b1; bif.op = OP_MULTU; bif.A = 32'd2; bif.B = 32'd3;
        @(posedge clk); #1;
        bif.start = 1'b0;
        check("div0_cleared", {63'd0, bif.div0}, 64'd0);
        done_seen = 0;
        for (int n = 0; n < 100 && done_seen == 0; n++) begin
            @(posedge clk); #1;
            if (bif.done === 1'b1) done_seen = 1;
        end
        check("multu_small_done", 64'(done_seen), 64'd1);
        check("multu_small_res", {bif.hi, bif.lo}, 64'd6);

        // start with mthi in IDLE: start wins, HI write dropped
        bif.mthi = 1'b1; bif.wdata = 32'h9999;
        run_op(OP_MULTU, 32'd3, 32'd3, lat);
        check("start_beats_mthi", {bif.hi, bif.lo}, 64'd9);

        // mthi and mtlo together write both
        bif.mthi = 1'b1; bif.mtlo = 1'b1; bif.wdata = 32'hCAFE;
        @(posedge clk); #1;
        bif.mthi = 1'b0; bif.mtlo = 1'b0;
        check("mthi_mtlo_both", {bif.hi, bif.lo}, 64'h0000_CAFE_0000_CAFE);

        // Preload HI/LO separately
        bif.mthi = 1'b1; bif.wdata = 32'h1234;
        @(posedge clk); #1;
        bif.mthi = 1'b0; bif.mtlo = 1'b1; bif.wdata = 32'h5678;
        @(posedge clk); #1;
        bif.mtlo = 1'b0;
        check("preload", {bif.hi, bif.lo}, 64'h0000_1234_0000_5678);

        // start + abort in IDLE: start ignored
        bif.start = 1'b1; bif.abort = 1'b1; bif.op = OP_DIVU; bif.A = 32'd9; bif.B = 32'd3;
        @(posedge clk); #1;
        bif.start = 1'b0; bif.abort = 1'b0;
        check("idle_abort_start", {63'd0, bif.busy}, 64'd0);

        // DIV, ignored start/mthi at cycle 3, abort at cycle 10
        bif.start = 1'b1; bif.op = OP_DIV; bif.A = 32'd100; bif.B = 32'd7;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bif.start = 1'b1; bif.mthi = 1'b1; bif.wdata = 32'hDEAD;
        @(posedge clk); #1;
        bif.start = 1'b0; bif.mthi = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("busy_before_abort", {63'd0, bif.busy}, 64'd1);
        bif.abort = 1'b1;
        @(posedge clk); #1;
        bif.abort = 1'b0;
        check("abort_busy", {62'd0, bif.busy, bif.done}, 64'd0);
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bif.done !== 1'b0 || bif.busy !== 1'b0) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_hilo", {bif.hi, bif.lo}, 64'h0000_1234_0000_5678);

        // Asynchronous reset mid-CALC
        bif.start = 1'b1; bif.op = OP_MULT; bif.A = 32'd11; bif.B = 32'hFFFF_0000;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_hilo", {bif.hi, bif.lo}, 64'd0);
        check("async_reset_flags", {61'd0, bif.busy, bif.done, bif.div0}, 64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;

        // MULTU 9 * 2: early-termination timing when enabled
        run_op(OP_MULTU, 32'd9, 32'd2, lat);
        check("et_lat", 64'(lat), 64'(exp_lat(OP_MULTU, 32'd2)));
        check("et_res", {bif.hi, bif.lo}, 64'd18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
